// File: rtl/axis_pkt_checker.sv
// AXI4-Stream sink that checks an incrementing payload pattern and the packet length.
// Define AXIS_CHK_ERR_CAPTURE_EN to add first-mismatch capture outputs.
module axis_pkt_checker #(
  parameter int TDATA_WIDTH = 8,
  parameter int LEN_WIDTH   = 8,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                   s_axis_tkeep,
  input  logic                   s_axis_tlast,
  input  logic                   enable,
  input  logic [LEN_WIDTH-1:0]   cfg_pkt_len,
  input  logic [TDATA_WIDTH-1:0] cfg_seed,
  input  logic [7:0]             cfg_ready_mask,
  output logic [CNT_WIDTH-1:0]   pkt_count,
  output logic [CNT_WIDTH-1:0]   data_err_count,
  output logic [CNT_WIDTH-1:0]   len_err_count,
  output logic                   busy,
`ifdef AXIS_CHK_ERR_CAPTURE_EN
  output logic [TDATA_WIDTH-1:0] err_exp,
  output logic [TDATA_WIDTH-1:0] err_act,
  output logic [CNT_WIDTH-1:0]   err_pkt,
  output logic [LEN_WIDTH-1:0]   err_beat,
`endif
  output logic                   err_flag
);

  typedef enum logic [1:0] {IDLE, RECV, DRAIN} state_t;

  state_t                 state_reg;
  logic [2:0]             slot_reg;
  logic                   tready_reg;
  logic [TDATA_WIDTH-1:0] exp_reg;
  logic [TDATA_WIDTH-1:0] pkt_idx_reg;
  logic [LEN_WIDTH-1:0]   len_reg;
  logic [LEN_WIDTH-1:0]   beat_reg;
  logic [CNT_WIDTH-1:0]   pkt_count_reg;
  logic [CNT_WIDTH-1:0]   data_err_reg;
  logic [CNT_WIDTH-1:0]   len_err_reg;
  logic                   err_flag_reg;

  logic                   accept;
  logic                   done;
  logic                   checking;
  logic [LEN_WIDTH-1:0]   cfg_len_eff;
  logic [LEN_WIDTH-1:0]   cur_len;
  logic [LEN_WIDTH-1:0]   beat_num;
  logic [TDATA_WIDTH-1:0] cur_exp;
  logic                   at_len;
  logic                   data_bad;
  logic                   len_bad;

  // In IDLE the live config applies (packet start); afterwards the values latched at start.
  always_comb begin
    accept      = s_axis_tvalid & tready_reg;
    done        = accept & s_axis_tlast;
    checking    = accept & (state_reg != DRAIN);
    cfg_len_eff = (cfg_pkt_len == '0) ? LEN_WIDTH'(1) : cfg_pkt_len;
    cur_len     = (state_reg == IDLE) ? cfg_len_eff : len_reg;
    beat_num    = (state_reg == IDLE) ? LEN_WIDTH'(1) : beat_reg + LEN_WIDTH'(1);
    cur_exp     = (state_reg == IDLE) ? cfg_seed + pkt_idx_reg : exp_reg;
    at_len      = (beat_num == cur_len);
    data_bad    = checking & ((s_axis_tdata != cur_exp) | ~s_axis_tkeep);
    len_bad     = checking & (s_axis_tlast ? ~at_len : at_len);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_reg     <= IDLE;
      slot_reg      <= 3'd0;
      tready_reg    <= 1'b0;
      exp_reg       <= cfg_seed;
      pkt_idx_reg   <= '0;
      len_reg       <= LEN_WIDTH'(1);
      beat_reg      <= '0;
      pkt_count_reg <= '0;
      data_err_reg  <= '0;
      len_err_reg   <= '0;
      err_flag_reg  <= 1'b0;
    end else begin
      tready_reg <= enable & cfg_ready_mask[slot_reg];
      if (enable) slot_reg <= slot_reg + 3'd1;

      if (accept) begin
        exp_reg  <= cur_exp + TDATA_WIDTH'(1);
        beat_reg <= beat_num;
        if (state_reg == IDLE) len_reg <= cfg_len_eff;
        if (s_axis_tlast)            state_reg <= IDLE;
        else if (state_reg == DRAIN) state_reg <= DRAIN;
        else if (at_len)             state_reg <= DRAIN;
        else                         state_reg <= RECV;
      end

      if (done) pkt_idx_reg <= pkt_idx_reg + TDATA_WIDTH'(1);
      if (done && pkt_count_reg != '1)    pkt_count_reg <= pkt_count_reg + CNT_WIDTH'(1);
      if (data_bad && data_err_reg != '1) data_err_reg  <= data_err_reg + CNT_WIDTH'(1);
      if (len_bad && len_err_reg != '1)   len_err_reg   <= len_err_reg + CNT_WIDTH'(1);
      if (data_bad || len_bad)            err_flag_reg  <= 1'b1;
    end
  end

`ifdef AXIS_CHK_ERR_CAPTURE_EN
  logic                   captured_reg;
  logic [TDATA_WIDTH-1:0] err_exp_reg;
  logic [TDATA_WIDTH-1:0] err_act_reg;
  logic [CNT_WIDTH-1:0]   err_pkt_reg;
  logic [LEN_WIDTH-1:0]   err_beat_reg;

  // Only the first payload mismatch after reset is kept.
  always_ff @(posedge aclk) begin
    if (areset) begin
      captured_reg <= 1'b0;
      err_exp_reg  <= '0;
      err_act_reg  <= '0;
      err_pkt_reg  <= '0;
      err_beat_reg <= '0;
    end else if (data_bad && !captured_reg) begin
      captured_reg <= 1'b1;
      err_exp_reg  <= cur_exp;
      err_act_reg  <= s_axis_tdata;
      err_pkt_reg  <= CNT_WIDTH'(pkt_idx_reg);
      err_beat_reg <= beat_num;
    end
  end

  assign err_exp  = err_exp_reg;
  assign err_act  = err_act_reg;
  assign err_pkt  = err_pkt_reg;
  assign err_beat = err_beat_reg;
`endif

  assign s_axis_tready  = tready_reg;
  assign pkt_count      = pkt_count_reg;
  assign data_err_count = data_err_reg;
  assign len_err_count  = len_err_reg;
  assign busy           = (state_reg != IDLE);
  assign err_flag       = err_flag_reg;

endmodule

// File: tb/tb_axis_pkt_checker.sv
// Directed bench for axis_pkt_checker; a second instance with 2-bit counters checks saturation.
module tb_axis_pkt_checker;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        tvalid = 1'b0;
  logic [7:0]  tdata = 8'h00;
  logic        tkeep = 1'b1;
  logic        tlast = 1'b0;
  logic        enable = 1'b1;
  logic [7:0]  cfg_pkt_len = 8'd4;
  logic [7:0]  cfg_seed = 8'h00;
  logic [7:0]  cfg_ready_mask = 8'hFF;

  logic        tready, busy, err_flag;
  logic [15:0] pkt_count, data_err_count, len_err_count;
  logic        tready_s, busy_s, err_flag_s;
  logic [1:0]  pkt_count_s, data_err_s, len_err_s;
`ifdef AXIS_CHK_ERR_CAPTURE_EN
  logic [7:0]  err_exp, err_act, err_exp_s, err_act_s;
  logic [15:0] err_pkt;
  logic [1:0]  err_pkt_s;
  logic [7:0]  err_beat, err_beat_s;
`endif

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  axis_pkt_checker dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tvalid(tvalid), .s_axis_tready(tready), .s_axis_tdata(tdata),
    .s_axis_tkeep(tkeep), .s_axis_tlast(tlast),
    .enable(enable), .cfg_pkt_len(cfg_pkt_len), .cfg_seed(cfg_seed),
    .cfg_ready_mask(cfg_ready_mask),
    .pkt_count(pkt_count), .data_err_count(data_err_count), .len_err_count(len_err_count),
    .busy(busy),
`ifdef AXIS_CHK_ERR_CAPTURE_EN
    .err_exp(err_exp), .err_act(err_act), .err_pkt(err_pkt), .err_beat(err_beat),
`endif
    .err_flag(err_flag)
  );

  axis_pkt_checker #(.CNT_WIDTH(2)) dut_sat (
    .aclk(aclk), .areset(areset),
    .s_axis_tvalid(tvalid), .s_axis_tready(tready_s), .s_axis_tdata(tdata),
    .s_axis_tkeep(tkeep), .s_axis_tlast(tlast),
    .enable(enable), .cfg_pkt_len(cfg_pkt_len), .cfg_seed(cfg_seed),
    .cfg_ready_mask(cfg_ready_mask),
    .pkt_count(pkt_count_s), .data_err_count(data_err_s), .len_err_count(len_err_s),
    .busy(busy_s),
`ifdef AXIS_CHK_ERR_CAPTURE_EN
    .err_exp(err_exp_s), .err_act(err_act_s), .err_pkt(err_pkt_s), .err_beat(err_beat_s),
`endif
    .err_flag(err_flag_s)
  );

  task automatic do_reset(input logic [7:0] seed, input logic [7:0] len, input logic [7:0] mask);
    @(negedge aclk);
    cfg_seed = seed; cfg_pkt_len = len; cfg_ready_mask = mask;
    tvalid = 1'b0; tlast = 1'b0; tkeep = 1'b1; enable = 1'b1;
    areset = 1'b1;
    repeat (2) @(negedge aclk);
    areset = 1'b0;
  endtask

  // Present one beat at a negedge and return at the negedge after it was accepted.
  task automatic send_beat(input logic [7:0] d, input logic last, input logic keep);
    int wait_cycles = 0;
    tvalid = 1'b1; tdata = d; tlast = last; tkeep = keep;
    while (tready !== 1'b1 && wait_cycles < 200) begin
      @(negedge aclk);
      wait_cycles++;
    end
    checks++;
    if (tready !== 1'b1) begin
      errors++;
      $display("FAIL handshake_timeout data=%h tready=%b required 1", d, tready);
    end
    @(negedge aclk);
    tvalid = 1'b0; tlast = 1'b0; tkeep = 1'b1;
  endtask

  task automatic send_pkt(input logic [7:0] first, input int n, input int bad_idx,
                          input logic [7:0] bad_val);
    logic [7:0] d;
    d = first;
    for (int i = 1; i <= n; i++) begin
      send_beat((i == bad_idx) ? bad_val : d, (i == n), 1'b1);
      d = d + 8'd1;
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic test_reset;
    do_reset(8'h10, 8'd4, 8'hFF);
    chk16("reset_pkt_count", pkt_count, 16'd0);
    chk16("reset_data_err", data_err_count, 16'd0);
    chk16("reset_len_err", len_err_count, 16'd0);
    chk16("reset_err_flag", {15'd0, err_flag}, 16'd0);
    chk16("reset_busy", {15'd0, busy}, 16'd0);
    chk16("reset_tready", {15'd0, tready}, 16'd0);
    $display("test_reset done");
  endtask

  task automatic test_basic_pass;
    do_reset(8'h10, 8'd4, 8'hFF);
    send_pkt(8'h10, 4, 0, 8'h00);
    send_pkt(8'h11, 4, 0, 8'h00);
    send_pkt(8'h12, 4, 0, 8'h00);
    @(negedge aclk);
    chk16("basic_pkt_count", pkt_count, 16'd3);
    chk16("basic_data_err", data_err_count, 16'd0);
    chk16("basic_len_err", len_err_count, 16'd0);
    chk16("basic_err_flag", {15'd0, err_flag}, 16'd0);
    chk16("basic_sat_pkt_count", {14'd0, pkt_count_s}, 16'd3);
    $display("test_basic_pass pkts=%0d", pkt_count);
  endtask

  task automatic test_backpressure;
    logic prev;
    do_reset(8'h40, 8'd8, 8'b0101_0101);
    repeat (2) @(negedge aclk);
    prev = tready;
    for (int i = 0; i < 7; i++) begin
      @(negedge aclk);
      checks++;
      if (tready !== ~prev) begin
        errors++;
        $display("FAIL bp_toggle cycle=%0d tready=%b required %b", i, tready, ~prev);
      end
      prev = tready;
    end
    send_pkt(8'h40, 8, 0, 8'h00);
    send_pkt(8'h41, 8, 0, 8'h00);
    @(negedge aclk);
    chk16("bp_pkt_count", pkt_count, 16'd2);
    chk16("bp_data_err", data_err_count, 16'd0);
    chk16("bp_len_err", len_err_count, 16'd0);
    $display("test_backpressure pkts=%0d", pkt_count);
  endtask

  task automatic test_data_error;
    do_reset(8'h00, 8'd4, 8'hFF);
    send_pkt(8'h00, 4, 3, 8'hAA);
    @(negedge aclk);
    chk16("derr_data_err", data_err_count, 16'd1);
    chk16("derr_pkt_count", pkt_count, 16'd1);
    chk16("derr_len_err", len_err_count, 16'd0);
    chk16("derr_err_flag", {15'd0, err_flag}, 16'd1);
`ifdef AXIS_CHK_ERR_CAPTURE_EN
    chk16("cap_exp", {8'd0, err_exp}, 16'h02);
    chk16("cap_act", {8'd0, err_act}, 16'hAA);
    chk16("cap_pkt", err_pkt, 16'd0);
    chk16("cap_beat", {8'd0, err_beat}, 16'd3);
`endif
    // Packet 1 (01..04) with tkeep dropped on its first beat.
    send_beat(8'h01, 1'b0, 1'b0);
    send_beat(8'h02, 1'b0, 1'b1);
    send_beat(8'h03, 1'b0, 1'b1);
    send_beat(8'h04, 1'b1, 1'b1);
    @(negedge aclk);
    chk16("tkeep_data_err", data_err_count, 16'd2);
    chk16("tkeep_pkt_count", pkt_count, 16'd2);
`ifdef AXIS_CHK_ERR_CAPTURE_EN
    chk16("cap_hold_beat", {8'd0, err_beat}, 16'd3);
    chk16("cap_hold_act", {8'd0, err_act}, 16'hAA);
`endif
    $display("test_data_error derr=%0d", data_err_count);
  endtask

  task automatic test_len_error;
    do_reset(8'h30, 8'd4, 8'hFF);
    send_pkt(8'h30, 2, 0, 8'h00);
    @(negedge aclk);
    chk16("early_len_err", len_err_count, 16'd1);
    chk16("early_pkt_count", pkt_count, 16'd1);
    chk16("early_busy", {15'd0, busy}, 16'd0);
    // Packet 1: four good beats, then two junk beats that must be drained unchecked.
    send_beat(8'h31, 1'b0, 1'b1);
    send_beat(8'h32, 1'b0, 1'b1);
    send_beat(8'h33, 1'b0, 1'b1);
    send_beat(8'h34, 1'b0, 1'b1);
    chk16("late_len_err_on_entry", len_err_count, 16'd2);
    chk16("late_busy_drain", {15'd0, busy}, 16'd1);
    send_beat(8'h55, 1'b0, 1'b1);
    send_beat(8'h66, 1'b1, 1'b1);
    @(negedge aclk);
    chk16("late_len_err", len_err_count, 16'd2);
    chk16("late_pkt_count", pkt_count, 16'd2);
    chk16("late_data_err", data_err_count, 16'd0);
    send_pkt(8'h32, 4, 0, 8'h00);
    @(negedge aclk);
    chk16("third_pkt_count", pkt_count, 16'd3);
    chk16("third_data_err", data_err_count, 16'd0);
    chk16("third_len_err", len_err_count, 16'd2);
    $display("test_len_error lerr=%0d", len_err_count);
  endtask

  task automatic test_wrap_saturation;
    logic [7:0] first;
    do_reset(8'hFE, 8'd4, 8'hFF);
    first = 8'hFE;
    for (int p = 0; p < 5; p++) begin
      send_pkt(first, 4, 0, 8'h00);
      first = first + 8'd1;
    end
    @(negedge aclk);
    chk16("wrap_pkt_count", pkt_count, 16'd5);
    chk16("wrap_data_err", data_err_count, 16'd0);
    chk16("wrap_len_err", len_err_count, 16'd0);
    chk16("sat_pkt_count", {14'd0, pkt_count_s}, 16'd3);
    chk16("sat_data_err", {14'd0, data_err_s}, 16'd0);
    chk16("sat_err_flag", {15'd0, err_flag_s}, 16'd0);
    $display("test_wrap_saturation pkts=%0d sat=%0d", pkt_count, pkt_count_s);
  endtask

  task automatic test_reset_mid_packet;
    do_reset(8'h20, 8'd4, 8'hFF);
    send_pkt(8'h20, 4, 0, 8'h00);
    send_beat(8'h21, 1'b0, 1'b1);
    send_beat(8'h22, 1'b0, 1'b1);
    chk16("mid_pre_pkt_count", pkt_count, 16'd1);
    areset = 1'b1;
    @(negedge aclk);
    chk16("mid_tready", {15'd0, tready}, 16'd0);
    chk16("mid_sat_tready", {15'd0, tready_s}, 16'd0);
    chk16("mid_pkt_count", pkt_count, 16'd0);
    chk16("mid_busy", {15'd0, busy}, 16'd0);
    areset = 1'b0;
    send_pkt(8'h20, 4, 0, 8'h00);
    @(negedge aclk);
    chk16("fresh_pkt_count", pkt_count, 16'd1);
    chk16("fresh_data_err", data_err_count, 16'd0);
    chk16("fresh_len_err", len_err_count, 16'd0);
    $display("test_reset_mid_packet pkts=%0d", pkt_count);
  endtask

  initial begin
    test_reset;
    test_basic_pass;
    test_backpressure;
    test_data_error;
    test_len_error;
    test_wrap_saturation;
    test_reset_mid_packet;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_pkt_checker.md
Name: axis_pkt_checker

Overview:
- Hardware AXI4-Stream sink. It consumes the packet stream leaving the AXI FIFO (FIFO data_o/valid_o/ready_o side) and checks it.
- Checks per beat: payload against a deterministic incrementing pattern, and the tlast position against the configured packet length.
- Drives tready with a programmable backpressure pattern.
- Reports packet, data-error and length-error counts, so FIFO regressions can run without a slave VIP and scoreboard.

Parameters:
- TDATA_WIDTH, 8, payload width in bits.
- LEN_WIDTH, 8, width of cfg_pkt_len and of the beat counter.
- CNT_WIDTH, 16, width of the status counters.

Ports:
- aclk  in  1  clock; everything on rising edge.
- areset  in  1  synchronous, active-high reset.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tready  out  1  sink ready (registered).
- s_axis_tdata  in  TDATA_WIDTH  beat payload.
- s_axis_tkeep  in  1  byte qualifier.
- s_axis_tlast  in  1  last beat of packet.
- enable  in  1  accept traffic; 0 holds tready low.
- cfg_pkt_len  in  LEN_WIDTH  expected beats per packet, 1..2^LEN_WIDTH-1; 0 is treated as 1.
- cfg_seed  in  TDATA_WIDTH  first-beat value of packet 0.
- cfg_ready_mask  in  8  backpressure pattern; bit i = tready in pattern slot i.
- pkt_count  out  CNT_WIDTH  packets completed (tlast accepted).
- data_err_count  out  CNT_WIDTH  beats with payload mismatch.
- len_err_count  out  CNT_WIDTH  packets with wrong length.
- busy  out  1  high in RECV or DRAIN.
- err_flag  out  1  sticky; set on any error, cleared only by reset.

Behaviour:
- Reset (areset=1 at a clock edge):
  - tready=0; all counters=0; err_flag=0; state=IDLE; slot pointer=0; packet index=0; expected=cfg_seed.
  - Reset mid-packet abandons the packet with no count.
- Handshake: a beat is accepted when s_axis_tvalid & s_axis_tready on a rising edge. The sink never depends on tvalid to drive tready.
- tready generation:
  - Slot pointer p (3 bits) increments every cycle while enable=1 and wraps 7->0.
  - Next tready = enable & cfg_ready_mask[p]. One-cycle registered latency from enable/mask to tready.
  - mask=8'hFF gives full throughput.
- Expected data:
  - First beat of packet n = cfg_seed + n, mod 2^TDATA_WIDTH.
  - Each subsequent beat = previous expected + 1, wraps modulo 2^TDATA_WIDTH.
  - Packet index n wraps naturally.
- States:
  - IDLE: on an accepted beat, compare against the first-beat value; beat count=1.
    - tlast=1 with len=1 -> complete, stay IDLE.
    - tlast=1 with len>1 -> len error, complete, stay IDLE.
    - tlast=0 with len=1 -> len error, go to DRAIN.
    - tlast=0 with len>1 -> go to RECV.
  - RECV: each accepted beat is compared and the beat count increments.
    - tlast at count==len -> complete, go to IDLE.
    - tlast at count<len (early) -> len error, complete, go to IDLE.
    - count reaches len without tlast -> len error, go to DRAIN.
  - DRAIN: beats are accepted but not compared. tlast -> complete, go to IDLE. The len error is counted once, on entry.
- Completion:
  - pkt_count+1 on every accepted tlast.
  - The packet index increments at completion, so the expected value for packet n+1 restarts from seed+n+1 regardless of errors.
- Data error: data_err_count+1 per mismatching beat; multiple beats in one packet each count.
- All counters saturate at 2^CNT_WIDTH-1.
- err_flag is set the cycle after the first counted error.
- tkeep=0 on an accepted beat counts as a data error.
- Counters update one cycle after acceptance.
- cfg_* are sampled at each packet start (IDLE acceptance); changes mid-packet have no effect until the next packet.
- enable dropping mid-packet only stalls (tready low); state is retained.

Optional Feature:
- Macro: AXIS_CHK_ERR_CAPTURE_EN.
- Defined: adds outputs err_exp [TDATA_WIDTH], err_act [TDATA_WIDTH], err_pkt [CNT_WIDTH] and err_beat [LEN_WIDTH].
  - They capture expected value, actual value, packet index and beat index (1-based) of the first data mismatch after reset.
  - They hold those values until reset; reset value 0.
- Undefined: those ports do not exist and there is no capture logic; all other behaviour is identical.

Test Plan:
- Basic pass: seed=8'h10, len=4, mask=FF, 3 clean packets (10..13, 11..14, 12..15) -> pkt_count=3, data_err_count=0, len_err_count=0, err_flag=0.
- Backpressure: mask=8'b0101_0101, 2 clean packets of len=8 -> tready toggles every cycle, no beat lost, pkt_count=2, no errors.
- Data error: len=4, seed=0, beat 3 sent as 8'hAA instead of 8'h02 -> data_err_count=1, pkt_count=1, err_flag=1; with the macro defined, err_exp=02, err_act=AA, err_pkt=0, err_beat=3.
- Early/late tlast: len=4, tlast on beat 2 -> len_err_count=1, pkt_count=1. Next packet of 6 beats with tlast on beat 6 -> len_err_count=2, DRAIN until beat 6, pkt_count=2. Third packet seeded at seed+2 checks clean.
- Wrap: seed=8'hFE, len=4 -> expected FE,FF,00,01 passes; counter saturation forced with CNT_WIDTH=2 and 5 packets -> pkt_count=3.
- Reset mid-packet: areset asserted after beat 2 of 4 -> next cycle tready=0, counters 0; a fresh packet starting at seed is checked clean.
